// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serialStateT;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// FullAdder: one-bit full adder used as the bit-slice datapath of the serial sequencer.
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add over WIDTH cycles through one FullAdder and a carry flop.
// Defining SERIAL_SUB_EN adds subtract support (opA - opB) selected by subMode.
module serial_add_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             subMode,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] result,
  output logic             cOut,
  output logic             overflow
);

  localparam int              CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serialStateT      stateQ, stateD;
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic [WIDTH-1:0] resQ, resD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             carryQ, carryD;
  logic             msbCinQ, msbCinD;
  logic             accept;
  logic             loadMode;
  logic             bBit;
  logic             sumBit;
  logic             carryOut;

  assign accept = startValid && (stateQ == IDLE);

`ifdef SERIAL_SUB_EN
  logic modeQ, modeD;

  // Subtract is A + ~B + 1: B is inverted here and the +1 is the carry preset at accept.
  assign loadMode = subMode ? MODE_SUB : MODE_ADD;
  assign modeD    = accept ? loadMode : modeQ;
  assign bBit     = bQ[0] ^ (modeQ == MODE_SUB);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      modeQ <= MODE_ADD;
    end else begin
      modeQ <= modeD;
    end
  end
`else
  logic unusedSubMode;

  assign unusedSubMode = subMode;
  assign loadMode      = MODE_ADD;
  assign bBit          = bQ[0];
`endif

  FullAdder u_bitSlice (
    .a_i    (aQ[0]),
    .b_i    (bBit),
    .c_i    (carryQ),
    .sum_o  (sumBit),
    .carry_o(carryOut)
  );

  always_comb begin
    stateD  = stateQ;
    aD      = aQ;
    bD      = bQ;
    resD    = resQ;
    cntD    = cntQ;
    carryD  = carryQ;
    msbCinD = msbCinQ;
    unique case (stateQ)
      IDLE: begin
        if (startValid) begin
          aD     = opA;
          bD     = opB;
          cntD   = '0;
          carryD = (loadMode == MODE_SUB);
          stateD = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
        resD   = {sumBit, resQ[WIDTH-1:1]};
        carryD = carryOut;
        aD     = aQ >> 1;
        bD     = bQ >> 1;
        cntD   = cntQ + CNT_W'(1);
        if (cntQ == LAST_BIT) begin
          msbCinD = carryQ;
          stateD  = DONE;
        end
      end
      DONE: begin
        if (resReady) begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ  <= IDLE;
      aQ      <= '0;
      bQ      <= '0;
      resQ    <= '0;
      cntQ    <= '0;
      carryQ  <= 1'b0;
      msbCinQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      aQ      <= aD;
      bQ      <= bD;
      resQ    <= resD;
      cntQ    <= cntD;
      carryQ  <= carryD;
      msbCinQ <= msbCinD;
    end
  end

  assign startReady = (stateQ == IDLE);
  assign resValid   = (stateQ == DONE);
  assign result     = resQ;
  assign cOut       = carryQ;
  assign overflow   = msbCinQ ^ carryQ;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: checks the serial adder at WIDTH=8 and WIDTH=32 against an arithmetic model.
// Subtract cases follow SERIAL_SUB_EN; without it subMode must be ignored.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;

  logic        sv8 = 1'b0, sr8, sub8 = 1'b0, rv8, rr8 = 1'b1, co8, ov8;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic        sv32 = 1'b0, sr32, sub32 = 1'b0, rv32, rr32 = 1'b0, co32, ov32;
  logic [31:0] a32 = '0, b32 = '0, res32;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount = cycleCount + 1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rstN(rstN), .startValid(sv8), .startReady(sr8),
    .opA(a8), .opB(b8), .subMode(sub8), .resValid(rv8), .resReady(rr8),
    .result(res8), .cOut(co8), .overflow(ov8)
  );

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rstN(rstN), .startValid(sv32), .startReady(sr32),
    .opA(a32), .opB(b32), .subMode(sub32), .resValid(rv32), .resReady(rr32),
    .result(res32), .cOut(co32), .overflow(ov32)
  );

  // Returns {overflow, carry, result}; overflow is the two's-complement sign rule.
  function automatic logic [33:0] refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
    logic [63:0] mask, bb, full;
    logic [31:0] res;
    logic        eff, co, ov;
    eff  = sub & SUB_EN;
    mask = (64'd1 << w) - 64'd1;
    bb   = eff ? (~{32'd0, b} & mask) : {32'd0, b};
    full = {32'd0, a} + bb + {63'd0, eff};
    res  = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (res[w-1] != a[w-1]);
    return {ov, co, res};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                output int latency);
    @(negedge clk);
    checkOutput("ready8_before", 64'(sr8), 64'd1);
    a8 = a; b8 = b; sub8 = sub; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~sub;
    latency = 0;
    while (!rv8 && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic runCase8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic [7:0] expRes, input logic expC, input logic expOv);
    int latency;
    applyStimulus8(a, b, sub, latency);
    checkOutput({tag, "_latency"}, 64'(latency), 64'd8);
    checkOutput({tag, "_result"}, 64'(res8), 64'(expRes));
    checkOutput({tag, "_cout"}, 64'(co8), 64'(expC));
    checkOutput({tag, "_ovf"}, 64'(ov8), 64'(expOv));
    @(posedge clk); #1;
    checkOutput({tag, "_done1cyc"}, 64'(rv8), 64'd0);
    checkOutput({tag, "_readyback"}, 64'(sr8), 64'd1);
  endtask

  task automatic waitResult32(output int latency);
    latency = 0;
    while (!rv32 && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [33:0] exp;
    logic [31:0] curA, curB;
    logic        curS;
    logic [7:0]  ra, rb;
    logic        rs;
    int          latency, guard, acceptCycle, prevAccept;
    bit          sawValid;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    checkOutput("rst_ready8", 64'(sr8), 64'd1);
    checkOutput("rst_valid8", 64'(rv8), 64'd0);
    checkOutput("rst_result8", 64'(res8), 64'd0);
    checkOutput("rst_cout8", 64'(co8), 64'd0);
    checkOutput("rst_ovf8", 64'(ov8), 64'd0);
    checkOutput("rst_ready32", 64'(sr32), 64'd1);
    checkOutput("rst_valid32", 64'(rv32), 64'd0);
    checkOutput("rst_result32", 64'(res32), 64'd0);
    rstN = 1'b1;

    runCase8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runCase8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
`ifdef SERIAL_SUB_EN
    runCase8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    runCase8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
    runCase8("nosub_05_07", 8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0);
    runCase8("nosub_80_01", 8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      exp = refModel(8, {24'd0, ra}, {24'd0, rb}, rs);
      runCase8("rand8", ra, rb, rs, exp[7:0], exp[32], exp[33]);
    end

    // Reset during the fourth RUN cycle aborts without a result.
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; sub8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abort_ready8", 64'(sr8), 64'd1);
    checkOutput("abort_valid8", 64'(rv8), 64'd0);
    checkOutput("abort_result8", 64'(res8), 64'd0);
    checkOutput("abort_cout8", 64'(co8), 64'd0);
    checkOutput("abort_ovf8", 64'(ov8), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rv8) sawValid = 1'b1;
    end
    checkOutput("abort_novalid8", 64'(sawValid), 64'd0);
    checkOutput("abort_idle8", 64'(sr8), 64'd1);

    // WIDTH=32 result held through a stalled consumer while new starts are ignored.
    @(negedge clk);
    curA = $urandom; curB = $urandom; curS = 1'($urandom);
    a32 = curA; b32 = curB; sub32 = curS; sv32 = 1'b1; rr32 = 1'b0;
    exp = refModel(32, curA, curB, curS);
    @(posedge clk); #1;
    sv32 = 1'b0;
    waitResult32(latency);
    checkOutput("stall_latency", 64'(latency), 64'd32);
    checkOutput("stall_result", 64'(res32), 64'(exp[31:0]));
    checkOutput("stall_cout", 64'(co32), 64'(exp[32]));
    checkOutput("stall_ovf", 64'(ov32), 64'(exp[33]));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sv32 = 1'b1; a32 = $urandom; b32 = $urandom;
      @(posedge clk); #1;
      checkOutput("stall_hold_valid", 64'(rv32), 64'd1);
      checkOutput("stall_hold_ready", 64'(sr32), 64'd0);
      checkOutput("stall_hold_result", 64'(res32), 64'(exp[31:0]));
      checkOutput("stall_hold_cout", 64'(co32), 64'(exp[32]));
    end
    @(negedge clk);
    sv32 = 1'b0; rr32 = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_release_valid", 64'(rv32), 64'd0);
    checkOutput("stall_release_ready", 64'(sr32), 64'd1);

    // Back-to-back random operations with startValid held and the consumer always ready.
    @(negedge clk);
    a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); sv32 = 1'b1;
    prevAccept = 0;
    for (int i = 0; i < 1000; i++) begin
      curA = a32; curB = b32; curS = sub32;
      guard = 0;
      while (!sr32 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        checkOutput("b2b_ready_timeout", 64'(sr32), 64'd1);
        break;
      end
      @(posedge clk); #1;
      acceptCycle = cycleCount;
      a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
      if (i > 0) checkOutput("b2b_spacing", 64'(acceptCycle - prevAccept), 64'd34);
      prevAccept = acceptCycle;
      exp = refModel(32, curA, curB, curS);
      waitResult32(latency);
      checkOutput("b2b_latency", 64'(latency), 64'd32);
      checkOutput("b2b_result", 64'(res32), 64'(exp[31:0]));
      checkOutput("b2b_cout", 64'(co32), 64'(exp[32]));
      checkOutput("b2b_ovf", 64'(ov32), 64'(exp[33]));
      @(negedge clk);
    end
    sv32 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer. It time-shares one `FullAdder` instance and a carry flop to compute a `WIDTH`-bit sum over `WIDTH` cycles. Operands arrive and results leave on valid/ready handshakes. It is the low-area alternative to the 32-bit ripple adder inside the ALU, intended for multi-cycle ops and the coprocessor path.

## Interface
- `WIDTH`, default 32: operand/result width; legal range is 2 and up.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstN`  in  1: asynchronous, active-low reset.
- `startValid`  in  1: operand set valid.
- `startReady`  out  1: block can accept operands.
- `opA`  in  WIDTH: first operand.
- `opB`  in  WIDTH: second operand.
- `subMode`  in  1: 1 = compute opA − opB (only with SERIAL_SUB_EN).
- `resValid`  out  1: result valid.
- `resReady`  in  1: consumer accepts result.
- `result`  out  WIDTH: sum/difference.
- `cOut`  out  1: carry out of MSB; for subtract, 1 = no borrow.
- `overflow`  out  1: signed overflow, equal to carry-into-MSB XOR cOut.

## Operation
- FSM states: IDLE, RUN, DONE.
  - Reset state is IDLE.
  - IDLE→RUN on `startValid && startReady`.
  - RUN→DONE when the bit counter reaches WIDTH−1.
  - DONE→IDLE on `resValid && resReady`.
- `startReady` = (state==IDLE). `resValid` = (state==DONE).
- On accept:
  - Latch opA and opB into right-shift registers.
  - Clear the bit counter.
  - Load the carry flop with 0 (add), or with 1 (subtract, when enabled).
  - Latch the mode bit.
- Each RUN cycle:
  - FullAdder inputs: A[0], B[0] (inverted when subtracting), and the carry flop.
  - Sum bit shifts into result MSB. The result register shifts right, so after WIDTH cycles bit 0 holds the LSB.
  - Carry flop takes the adder cOut.
  - A and B shift right; counter increments.
- On the last RUN cycle, also latch the adder carry-in into a `msbCin` flop for overflow.
- In DONE, `result`, `cOut` and `overflow` hold stable until the handshake completes.
- Arithmetic is modulo 2^WIDTH. Operands are captured at accept, so opA/opB may change afterwards without effect.
- Reset at any point (including mid-RUN or DONE) aborts the operation. No partial result is emitted.
- Reset values:
  - state = IDLE
  - startReady = 1
  - resValid = 0
  - result = 0
  - cOut = 0
  - overflow = 0
  - counter, shift registers, carry flop = 0

## Timing
- Accept at edge T. RUN cycles are T+1 … T+WIDTH. `resValid` rises after edge T+WIDTH and holds until the handshake.
- Minimum accept-to-accept spacing is WIDTH+2 cycles. `startReady` reasserts the cycle after the result handshake; there is no same-cycle result/start overlap.
- `startValid` asserted while not ready is ignored; the requester must hold it.
- If `resReady` is held high, DONE lasts exactly one cycle.

## Configuration
- `SERIAL_SUB_EN` defined:
  - `subMode` is honoured. Subtract = invert B bits, carry-in 1.
  - The latched mode bit exists.
- `SERIAL_SUB_EN` undefined:
  - `subMode` is ignored and the block always adds with carry-in 0.
  - The mode flop and B inverter are removed.
  - The port stays, so integration is unchanged.

## Structure
- Shared package `serial_pkg`:
  - state enum (IDLE/RUN/DONE)
  - counter-width function clog2(WIDTH)
  - encoding constants for the mode bit
- One sub-module: the existing `FullAdder`, instantiated once as the bit-slice datapath. All sequencing and storage stays in `serial_add_ctrl`.

## Test plan
- WIDTH=8, 0xFF + 0x01 → result 0x00, cOut 1, overflow 0; `resValid` rises exactly 8 cycles after accept edge.
- WIDTH=8, 0x7F + 0x01 → result 0x80, cOut 0, overflow 1.
- SERIAL_SUB_EN, WIDTH=8:
  - 0x05 − 0x07 → 0xFE, cOut 0, overflow 0.
  - 0x80 − 0x01 → 0x7F, cOut 1, overflow 1.
- WIDTH=32, `resReady` held low 5 cycles in DONE → `result` stable; `startReady` stays 0; `startValid` pulses are ignored.
- `rstN` asserted at RUN cycle 4 → next state IDLE; all outputs 0; `startReady` 1; no `resValid` pulse.
- Back-to-back requests with `resReady`=1, WIDTH=32 → accepts spaced exactly 34 cycles; results match a reference model over 1000 random operand pairs.
